// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode instruction FIFO with flush and misaligned-PC tag.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PW      = AW + 1;
  localparam logic [31:0] C_NOP   = 32'h0000_0013;

  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_inst [DEPTH];
  logic            r_mem_mis  [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // in_ready depends only on reset and pointer state, never on out_ready.
  assign in_ready  = reset & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage carries no reset; validity is defined by the pointers alone.
  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem_pc[w_wr_idx]   <= in_pc;
      r_mem_inst[w_wr_idx] <= in_inst;
      r_mem_mis[w_wr_idx]  <= |in_pc[1:0];
    end
  end

  always_comb begin
    out_pc         = '0;
    out_inst       = C_NOP;
    out_misaligned = 1'b0;
    if (!w_empty) begin
      out_pc         = r_mem_pc[w_rd_idx];
      out_inst       = r_mem_inst[w_rd_idx];
      out_misaligned = r_mem_mis[w_rd_idx];
    end
  end

endmodule
`default_nettype wire
